// File: rtl/imem_loader.sv
// Boot-time loader: assembles a little-endian byte stream into 32-bit words, writes them to
// instruction memory and holds the core in reset until the halt word lands. Optional macro: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [31:0]       wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [31:0] HALT_WORD = 32'h0000_007F;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERR, S_CSUM} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERR} state_t;
`endif

  state_t            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              rx_ready_q, rx_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [31:0]       wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              core_rst_q, core_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              hs;
  logic [31:0]       word_asm;
  logic [ADDR_W:0]   word_count_inc;

  assign hs             = rx_valid & rx_ready_q;
  assign word_count_inc = word_count_q + {{ADDR_W{1'b0}}, 1'b1};

  // Each byte lane captures rx_data only on the handshake that targets it.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign word_asm[8*gi +: 8] = (hs && (byte_idx_q == 2'(gi))) ? rx_data : word_q[8*gi +: 8];
  end

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    csum_d       = csum_q;
    word_count_d = word_count_q;
    rx_ready_d   = rx_ready_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    core_rst_d   = core_rst_q;
    done_d       = done_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d      = S_RECV;
          rx_ready_d   = 1'b1;
          core_rst_d   = 1'b1;
          done_d       = 1'b0;
          err_d        = 1'b0;
          word_count_d = '0;
          byte_idx_d   = 2'd0;
          csum_d       = 8'h00;
        end
      end
      S_RECV: begin
        if (hs) begin
          word_d = word_asm;
          csum_d = csum_q ^ rx_data;
          if (byte_idx_q == 2'd3) begin
            state_d    = S_WRITE;
            byte_idx_d = 2'd0;
            rx_ready_d = 1'b0;
            wr_en_d    = 1'b1;
            // Index is below DEPTH here, so the shifted address never wraps.
            wr_addr_d  = {{(30-ADDR_W){1'b0}}, word_count_q[ADDR_W-1:0], 2'b00};
            wr_data_d  = word_asm;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        word_count_d = word_count_inc;
        if (wr_data_q == HALT_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d    = S_CSUM;
          rx_ready_d = 1'b1;
`else
          state_d    = S_DONE;
          done_d     = 1'b1;
          core_rst_d = 1'b0;
`endif
        end else if (word_count_inc == (ADDR_W+1)'(DEPTH)) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          state_d    = S_RECV;
          rx_ready_d = 1'b1;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (hs) begin
          rx_ready_d = 1'b0;
          if (rx_data == csum_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            core_rst_d = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= 2'd0;
      word_q       <= 32'h0;
      csum_q       <= 8'h00;
      word_count_q <= '0;
      rx_ready_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 32'h0;
      wr_data_q    <= 32'h0;
      core_rst_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      word_count_q <= word_count_d;
      rx_ready_q   <= rx_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      core_rst_q   <= core_rst_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign core_rst   = core_rst_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes and status snapshots,
// a single monitor process pops and compares them on the falling edge.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        core_rst;
  logic        done;
  logic        err;
  logic [5:0]  word_count;

  imem_loader #(.DEPTH(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_rst   (core_rst),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    string       name;
    logic [10:0] v;   // {core_rst, rx_ready, done, err, wr_en, word_count}
  } st_t;

  wr_t wr_q[$];
  st_t st_q[$];
  bit  finish_req = 1'b0;
  int  total = 0;
  int  bad = 0;

  // Monitor: the only process that compares and counts.
  initial begin
    wr_t         w;
    st_t         s;
    logic [10:0] act;
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        total++;
        if (wr_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write got addr=%08h data=%08h expected none", wr_addr, wr_data);
        end else begin
          w = wr_q.pop_front();
          if ({wr_addr, wr_data} !== {w.addr, w.data}) begin
            bad++;
            $display("FAIL write got addr=%08h data=%08h expected addr=%08h data=%08h",
                     wr_addr, wr_data, w.addr, w.data);
          end else begin
            $display("write addr=%08h data=%08h ok", wr_addr, wr_data);
          end
          total++;
          if (rx_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_in_write got rx_ready=%b expected 0", rx_ready);
          end
        end
      end
      if (st_q.size() > 0) begin
        s   = st_q.pop_front();
        act = {core_rst, rx_ready, done, err, wr_en, word_count};
        total++;
        if (act !== s.v) begin
          bad++;
          $display("FAIL %s got {core_rst,rx_ready,done,err,wr_en,wc}=%b,%b,%b,%b,%b,%0d expected %b,%b,%b,%b,%b,%0d",
                   s.name, act[10], act[9], act[8], act[7], act[6], act[5:0],
                   s.v[10], s.v[9], s.v[8], s.v[7], s.v[6], s.v[5:0]);
        end else begin
          $display("status %s ok", s.name);
        end
      end
      if (finish_req) begin
        total++;
        if (wr_q.size() != 0) begin
          bad++;
          $display("FAIL missing_writes got %0d pending expected 0", wr_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic expect_status(input string n, input bit cr, input bit rdy,
                               input bit dn, input bit er, input int wc);
    st_t s;
    s.name = n;
    s.v    = {cr, rdy, dn, er, 1'b0, 6'(wc)};
    st_q.push_back(s);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bp);
    int n;
    bit hs;
    n = 0;
    forever begin
      rx_data  = b;
      rx_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      hs       = rx_valid && (rx_ready === 1'b1);
      @(posedge clk);
      #1;
      if (hs) break;
      n++;
      if (n > 200) begin
        $display("FAIL send_timeout got no handshake expected byte %02h accepted", b);
        $fatal(1, "handshake timeout");
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] data, input bit bp);
    wr_t w;
    w.addr = addr;
    w.data = data;
    wr_q.push_back(w);
    for (int k = 0; k < 4; k++) send_byte(data[8*k +: 8], bp);
  endtask

  task automatic finish_load(input logic [7:0] csum, input bit bp);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(csum, bp);
`else
    if (csum == 8'h00 || bp) begin end
    @(posedge clk);
    #1;
`endif
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_status("reset", 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // Basic load.
    do_start();
    expect_status("start_from_idle", 1, 1, 0, 0, 0);
    send_word(32'h0, 32'h0060_0513, 1'b0);
    send_word(32'h4, 32'h0000_007F, 1'b0);
    finish_load(8'h09, 1'b0);
    expect_status("basic_done", 0, 0, 1, 0, 2);

    // Same program with random rx_valid gaps.
    do_start();
    expect_status("start_from_done", 1, 1, 0, 0, 0);
    send_word(32'h0, 32'h0060_0513, 1'b1);
    send_word(32'h4, 32'h0000_007F, 1'b1);
    finish_load(8'h09, 1'b1);
    expect_status("backpressure_done", 0, 0, 1, 0, 2);

    // Overflow: fill all 32 words without a halt.
    do_start();
    for (int i = 0; i < 32; i++) send_word(32'(i * 4), 32'h0000_0033, 1'b0);
    @(posedge clk);
    #1;
    expect_status("overflow_err", 1, 0, 0, 1, 32);
    rx_valid = 1'b1;
    rx_data  = 8'h33;
    repeat (3) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    expect_status("overflow_err_hold", 1, 0, 0, 1, 32);

    // Reset in the middle of a word.
    do_start();
    expect_status("start_from_err", 1, 1, 0, 0, 0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h05, 1'b0);
    pulse_rst();
    expect_status("mid_word_reset", 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    do_start();
    send_word(32'h0, 32'h0060_0513, 1'b0);
    @(posedge clk);
    #1;
    expect_status("after_reset_word", 1, 1, 0, 0, 1);
    do_start();
    expect_status("start_ignored_recv", 1, 1, 0, 0, 1);
    pulse_rst();

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_start();
    send_word(32'h0, 32'h0060_0513, 1'b0);
    send_word(32'h4, 32'h0000_007F, 1'b0);
    send_byte(8'h08, 1'b0);
    expect_status("csum_bad", 1, 0, 0, 1, 2);
    do_start();
    send_word(32'h0, 32'h0060_0513, 1'b0);
    send_word(32'h4, 32'h0000_007F, 1'b0);
    send_byte(8'h09, 1'b0);
    expect_status("csum_good", 0, 0, 1, 0, 2);
`endif

    @(posedge clk);
    #1;
    finish_req = 1'b1;
    forever @(posedge clk);
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the core's 32-bit instruction memory. Accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit words, and drives the instruction memory write port at word-aligned byte addresses. This matches the fetch-side indexing of `pc / 4`. The block holds the core in reset until the program's halt word (`0x0000007F`) has been written, then releases it.

## Interface
- `DEPTH`, 32: instruction memory size in words; loads beyond this are an error.
- `ADDR_W`, 5: word-index width, log2(`DEPTH`).
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: begin a load; honoured only in IDLE, DONE and ERR.
- `rx_data` in 8: incoming program byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts a byte this cycle.
- `wr_en` out 1: instruction memory write strobe, one cycle per word.
- `wr_addr` out 32: byte address of the write, always a multiple of 4.
- `wr_data` out 32: instruction word to write.
- `core_rst` out 1: holds the CPU in reset while high.
- `done` out 1: load completed successfully.
- `err` out 1: load failed (overflow, or checksum mismatch when enabled).
- `word_count` out `ADDR_W`+1: words written in the current load.

## Operation
- States: IDLE, RECV, WRITE, DONE, ERR; with `IMEM_LOADER_CHECKSUM_EN` also CSUM.
- Reset values: state IDLE, `core_rst`=1, `rx_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `done`=0, `err`=0, `word_count`=0, byte index 0.
- IDLE: `core_rst`=1. `start`=1 moves to RECV and clears `word_count`, byte index, `done` and `err`.
- RECV: `rx_ready`=1. On each `rx_valid & rx_ready` handshake, byte k (k = 0..3) is stored in bits [8k+7:8k] of the word.
  - After the 4th byte the state moves to WRITE and the byte index returns to 0.
- WRITE: `rx_ready`=0 and `wr_en`=1 for exactly one cycle, with `wr_addr` = `word_count`*4 and `wr_data` = the assembled word. `word_count` increments at the end of the cycle.
  - If the word is `0x0000007F`, go to DONE (or CSUM). The halt word itself is written.
  - Else if the incremented `word_count` equals `DEPTH`, go to ERR.
  - Else return to RECV.
- DONE: `done`=1, `core_rst`=0, `rx_ready`=0. `start` returns to RECV, with `core_rst`=1 from the next cycle.
- ERR: `err`=1, `core_rst`=1, `rx_ready`=0. Only `start` or `rst` leave this state.
- `start` is ignored in RECV, WRITE and CSUM.
- `rst` mid-load: all outputs return to reset values at the next edge. A partially assembled word is discarded and no write is issued. Memory contents are not cleared.
- Address arithmetic: `wr_addr` = {zero-extend(`word_count`[`ADDR_W`-1:0]), 2'b00}, never wrapping. The overflow check precedes any wrap.

## Timing
- All outputs are registered.
- `wr_en` rises in the cycle after the edge that accepts a word's 4th byte.
- Each word costs one `rx_ready`-low bubble, so peak throughput is 4 bytes per 5 cycles.
- `core_rst` falls and `done` rises in the cycle after the halt word's WRITE cycle.
- `rx_valid` may drop or gap arbitrarily. Bytes are consumed only on handshake, and `rx_data` is sampled only when `rx_valid & rx_ready`.
- If `rst` and `start` are asserted together, `rst` wins.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After the halt word's WRITE, the block enters CSUM with `rx_ready`=1 and accepts one extra byte.
  - That byte is compared with the XOR of every byte received in the current load.
  - Equal goes to DONE; unequal goes to ERR.
  - `core_rst` stays 1 throughout CSUM.
- Undefined: there is no CSUM state; WRITE of the halt word goes directly to DONE.

## Test plan
- Reset: hold `rst` for 1 edge from any state. Expect `core_rst`=1, `rx_ready`=0, `done`=0, `err`=0, `word_count`=0, `wr_en`=0.
- Basic load: `start`, then bytes 13 05 60 00 7F 00 00 00.
  - Expect a write of `0x00600513` at addr 0x0, then `0x0000007F` at 0x4.
  - Then `done`=1, `core_rst`=0, `word_count`=2.
  - With the macro, also send checksum 0x09 before `done`.
- Backpressure: the same stream with `rx_valid` randomly low 50% of cycles. Expect identical writes, `rx_ready`=0 in each WRITE cycle, and no lost or duplicated byte.
- Overflow: 32 words of `0x00000033` with no halt. Expect 32 writes at 0x0..0x7C, then `err`=1, `core_rst`=1, and `rx_ready`=0 thereafter.
- Reset mid-word: `start`, bytes 13 05, then `rst`. Expect no write. Then `start` and 4 bytes: expect a write at addr 0x0.
- Checksum (macro defined): basic load followed by 0x08. Expect `err`=1 and `core_rst`=1. Reload with 0x09: expect `done`=1.
